// File: rtl/npc_pc_unit.sv
// Next-PC generator with the fetch PC register and a one-entry redirect buffer.
// Picks the next fetch address from sequential, branch, jump, jump-register and exception targets.
//
// state | meaning
// IDLE  | no redirect buffered; pend_valid=0
// PEND  | a redirect arrived during a stall and waits in pend_target
module npc_pc_unit #(
  parameter int WIDTH = 32,
  parameter int OFF_W = 16,
  parameter int IDX_W = 26,
  parameter logic [WIDTH-1:0] RESET_PC    = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_HANDLER = 32'h0000_4180
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] pc_d,
  input  logic [OFF_W-1:0] off,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] rs_val,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc_in,
  output logic [WIDTH-1:0] pc,
  output logic             pend_valid,
  output logic             adel_if
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  localparam logic [WIDTH-1:0] FOUR = {{(WIDTH-3){1'b0}}, 3'd4};

  logic [0:0]       state;
  logic [WIDTH-1:0] pend_target;
  logic [WIDTH-1:0] off_sext;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] j_target;
  logic [WIDTH-1:0] redir_target;
  logic             redir;

  assign off_sext  = {{(WIDTH-OFF_W){off[OFF_W-1]}}, off};
  assign br_target = pc_d + FOUR + (off_sext << 2);

  // The jump keeps the upper region bits of pc_d; when none remain the index fills the PC.
  generate
    if (WIDTH > IDX_W + 2) begin : g_j_region
      assign j_target = {pc_d[WIDTH-1:IDX_W+2], idx, 2'b00};
    end else begin : g_j_full
      assign j_target = {idx, 2'b00};
    end
  endgenerate

  always_comb begin
    redir        = 1'b0;
    redir_target = '0;
    case (op)
      3'b001: begin redir = 1'b1; redir_target = br_target; end
      3'b010: begin redir = 1'b1; redir_target = j_target;  end
      3'b011: begin redir = 1'b1; redir_target = rs_val;    end
      default: begin redir = 1'b0; redir_target = '0;       end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      pend_target <= '0;
      state       <= IDLE;
    end else if (exc_req) begin
      pc          <= EXC_HANDLER;
      pend_target <= '0;
      state       <= IDLE;
    end else if (eret_req) begin
      pc          <= epc_in;
      pend_target <= '0;
      state       <= IDLE;
    end else if (stall) begin
      if (redir) begin
        pend_target <= redir_target;
        state       <= PEND;
      end
    end else if (redir) begin
      pc          <= redir_target;
      pend_target <= '0;
      state       <= IDLE;
    end else if (state == PEND) begin
      pc          <= pend_target;
      pend_target <= '0;
      state       <= IDLE;
    end else begin
      pc <= pc + FOUR;
    end
  end

  assign pend_valid = (state == PEND);
  assign adel_if    = |pc[1:0];

endmodule
